vram_arbiter: RTL

//  Shares the single-port synchronous VRAM (text + glyph areas) between the pixel generator and the CPU bus.
//  The pixel generator owns fixed slots (pixel_state 0 TEXT_FETCH, 1 GLYPH_FETCH) while video is active.
//  The CPU is served in free slots (pixel_state 2/3), or in any slot during blanking.

---
 rtl/vram_pkg.sv | 38 +++
 rtl/vram_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/vram_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Package  : vram_pkg
// Purpose  : Shared VRAM map, pixel slot encodings and arbiter FSM states
//            for the VRAM arbiter and its neighbours.
// Revision : 1.0 - initial release
// ============================================================================
package vram_pkg;

  localparam int VRAM_ADDR_W = 15;
  localparam int VRAM_DATA_W = 16;

  // Pixel slot phases from the timing generator
  typedef enum logic [1:0] {
    TEXT_FETCH     = 2'd0,
    GLYPH_FETCH    = 2'd1,
    SET_FOREGROUND = 2'd2,
    DRAW           = 2'd3
  } slot_e;

  // VRAM memory map (word addresses)
  localparam logic [VRAM_ADDR_W-1:0] ADDR_TEXT  = 15'd0;
  localparam logic [VRAM_ADDR_W-1:0] SIZE_TEXT  = 15'd8192;
  localparam logic [VRAM_ADDR_W-1:0] ADDR_GLYPH = 15'd8192;
  localparam logic [VRAM_ADDR_W-1:0] SIZE_GLYPH = 15'd24576;

  // Arbiter FSM states; ARB_ISSUE is reserved because the issue mux is
  // combinational out of ARB_IDLE.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_ACK   = 2'd3
  } arb_state_e;

endpackage : vram_pkg
`default_nettype wire

// File: rtl/vram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Purpose  : Shares the single-port synchronous VRAM between the pixel
//            generator (fixed slots 0/1 while video is active) and the CPU
//            (slots 2/3, or any slot during blanking).
// Revision : 1.0 - initial release
// Config   : VRAM_GLYPH_LOCK_EN - adds glyph_lock input and cpu_err output;
//            locked CPU writes into the glyph area are suppressed.
// Ports    :
//   clk, reset_n          clock, synchronous active-low reset
//   video_active          pixel generator enabled (changes only in slot 0)
//   pixel_state[1:0]      current pixel slot phase
//   pg_addr / pg_data     pixel generator address / read data (pass-through)
//   cpu_req/we/addr/wdata CPU request, held until cpu_ack
//   cpu_rdata / cpu_ack   CPU read data and one-cycle completion pulse
//   mem_addr/we/wdata     VRAM command
//   mem_rdata             VRAM read data, one cycle after mem_addr
//   glyph_lock / cpu_err  (VRAM_GLYPH_LOCK_EN only) write protect / error
// ============================================================================
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int                ADDR_W     = 15,
  parameter int                DATA_W     = 16,
  parameter logic [ADDR_W-1:0] ADDR_GLYPH = vram_pkg::ADDR_GLYPH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              video_active,
  input  logic [1:0]        pixel_state,
  input  logic [ADDR_W-1:0] pg_addr,
  output logic [DATA_W-1:0] pg_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
`ifdef VRAM_GLYPH_LOCK_EN
  input  logic              glyph_lock,
  output logic              cpu_err,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state_q, state_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              is_write_q, is_write_d;
  logic              err_pend_q, err_pend_d;
  logic              cpu_err_q, cpu_err_d;

  logic cpu_slot;
  logic issue;
  logic wr_blocked;

  // Slot decode: the pixel generator owns slots 0/1 only while active.
  always_comb begin
    cpu_slot = !video_active
             || (pixel_state == SET_FOREGROUND)
             || (pixel_state == DRAW);
    issue    = (state_q == ARB_IDLE) && cpu_req && cpu_slot;
  end

`ifdef VRAM_GLYPH_LOCK_EN
  always_comb begin
    wr_blocked = glyph_lock && cpu_we && (cpu_addr >= ADDR_GLYPH);
  end
  assign cpu_err = cpu_err_q;
`else
  always_comb begin
    wr_blocked = 1'b0;
  end
`endif

  // VRAM command mux: the CPU drives the RAM only in its issue cycle.
  always_comb begin
    mem_addr  = pg_addr;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (issue) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we && !wr_blocked;
      mem_wdata = cpu_wdata;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cpu_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    is_write_d  = is_write_q;
    err_pend_d  = err_pend_q;
    cpu_err_d   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (issue) begin
          state_d    = ARB_WAIT;
          is_write_d = cpu_we;
          err_pend_d = wr_blocked;
        end
      end
      ARB_WAIT: begin
        // RAM data for the issued address is present in this cycle.
        state_d     = ARB_ACK;
        cpu_ack_d   = 1'b1;
        cpu_rdata_d = is_write_q ? '0 : mem_rdata;
        cpu_err_d   = err_pend_q;
      end
      ARB_ACK: begin
        // No issue from here, so a held cpu_req waits for IDLE.
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ARB_IDLE;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      is_write_q  <= 1'b0;
      err_pend_q  <= 1'b0;
      cpu_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      is_write_q  <= is_write_d;
      err_pend_q  <= err_pend_d;
      cpu_err_q   <= cpu_err_d;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign pg_data   = mem_rdata;

endmodule : vram_arbiter
`default_nettype wire
